// File: rtl/cmul_mult_sequencer.sv
// Complex multiply y = a * w sequenced through one shared unsigned multiplier.
// Four products over M0..M3, then round-half-up, saturate and hold until taken.
module cmul_mult_sequencer #(
   parameter int WIDTH = 16,
   parameter int FRAC  = 15
) (
   input  logic               clk,
   input  logic               rst_n,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [WIDTH-1:0]   a_re,
   input  logic [WIDTH-1:0]   a_im,
   input  logic [WIDTH-1:0]   w_re,
   input  logic [WIDTH-1:0]   w_im,
   output logic [WIDTH-1:0]   mul_a,
   output logic [WIDTH-1:0]   mul_b,
   input  logic [2*WIDTH-1:0] mul_p,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [WIDTH-1:0]   y_re,
   output logic [WIDTH-1:0]   y_im,
   output logic               y_sat
);

   localparam int AW = 2*WIDTH + 2;
   localparam logic signed [AW-1:0] RND  = AW'(1) << (FRAC-1);
   localparam logic signed [AW-1:0] MAXV = AW'((64'd1 << (WIDTH-1)) - 64'd1);
   localparam logic signed [AW-1:0] MINV = ~MAXV;

   typedef enum logic [2:0] {
      S_IDLE, S_M0, S_M1, S_M2, S_M3, S_DONE
   } state_t;

   state_t r_state;

   logic [WIDTH-1:0] r_a_re, r_a_im, r_w_re, r_w_im;
   logic signed [AW-1:0] r_acc_re, r_acc_im;
   logic [WIDTH-1:0] r_y_re, r_y_im;
   logic r_y_sat, r_out_valid, r_in_ready;

   logic [WIDTH-1:0] w_x, w_y;
   logic w_neg;
   logic signed [AW-1:0] w_pext, w_sp;
   logic signed [AW-1:0] w_fin_im, w_rnd_re, w_rnd_im;
   logic [WIDTH:0] w_sat_re, w_sat_im;

   function automatic logic [WIDTH-1:0] mag(input logic [WIDTH-1:0] v);
      return v[WIDTH-1] ? (~v) + WIDTH'(1) : v;
   endfunction

   function automatic logic [WIDTH:0] clip(input logic signed [AW-1:0] r);
      if (r > MAXV)
         return {1'b1, MAXV[WIDTH-1:0]};
      else if (r < MINV)
         return {1'b1, MINV[WIDTH-1:0]};
      else
         return {1'b0, r[WIDTH-1:0]};
   endfunction

   // operand pair for the current product, taken only from captured registers
   always_comb begin
      w_x = '0;
      w_y = '0;
      unique case (r_state)
         S_M0: begin w_x = r_a_re; w_y = r_w_re; end
         S_M1: begin w_x = r_a_im; w_y = r_w_im; end
         S_M2: begin w_x = r_a_re; w_y = r_w_im; end
         S_M3: begin w_x = r_a_im; w_y = r_w_re; end
         default: begin w_x = '0; w_y = '0; end
      endcase
   end

   assign mul_a  = mag(w_x);
   assign mul_b  = mag(w_y);
   assign w_neg  = w_x[WIDTH-1] ^ w_y[WIDTH-1];
   assign w_pext = signed'({2'b00, mul_p});
   assign w_sp   = w_neg ? -w_pext : w_pext;

   assign w_fin_im = r_acc_im + w_sp;
   assign w_rnd_re = (r_acc_re + RND) >>> FRAC;
   assign w_rnd_im = (w_fin_im + RND) >>> FRAC;
   assign w_sat_re = clip(w_rnd_re);
   assign w_sat_im = clip(w_rnd_im);

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state     <= S_IDLE;
         r_a_re      <= '0;
         r_a_im      <= '0;
         r_w_re      <= '0;
         r_w_im      <= '0;
         r_acc_re    <= '0;
         r_acc_im    <= '0;
         r_y_re      <= '0;
         r_y_im      <= '0;
         r_y_sat     <= 1'b0;
         r_out_valid <= 1'b0;
         r_in_ready  <= 1'b1;
      end else begin
         unique case (r_state)
            S_IDLE: begin
               if (in_valid) begin
                  r_a_re     <= a_re;
                  r_a_im     <= a_im;
                  r_w_re     <= w_re;
                  r_w_im     <= w_im;
                  r_in_ready <= 1'b0;
                  r_state    <= S_M0;
               end
            end
            S_M0: begin
               r_acc_re <= w_sp;
               r_state  <= S_M1;
            end
            S_M1: begin
               r_acc_re <= r_acc_re - w_sp;
               r_state  <= S_M2;
            end
            S_M2: begin
               r_acc_im <= w_sp;
               r_state  <= S_M3;
            end
            S_M3: begin
               r_acc_im    <= w_fin_im;
               r_y_re      <= w_sat_re[WIDTH-1:0];
               r_y_im      <= w_sat_im[WIDTH-1:0];
               r_y_sat     <= w_sat_re[WIDTH] | w_sat_im[WIDTH];
               r_out_valid <= 1'b1;
               r_state     <= S_DONE;
            end
            S_DONE: begin
               if (out_ready) begin
                  r_out_valid <= 1'b0;
                  r_in_ready  <= 1'b1;
                  r_state     <= S_IDLE;
               end
            end
            default: begin
               r_state <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready  = r_in_ready;
   assign out_valid = r_out_valid;
   assign y_re      = r_y_re;
   assign y_im      = r_y_im;
   assign y_sat     = r_y_sat;

endmodule

// File: tb/tb_cmul_mult_sequencer.sv
// Scoreboard bench for cmul_mult_sequencer: directed cases plus random ops
// against an integer-arithmetic reference of the complex multiply.
module tb_cmul_mult_sequencer;

   typedef struct {
      logic [15:0] re;
      logic [15:0] im;
      logic        sat;
      int          acc;
   } exp_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [15:0] a_re = '0, a_im = '0, w_re = '0, w_im = '0;
   logic [15:0] mul_a, mul_b;
   logic [31:0] mul_p;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [15:0] y_re, y_im;
   logic        y_sat;

   exp_t sb[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   n_push = 0;
   int   n_pop = 0;
   int   cyc = 0;
   bit   rnd_rdy = 0;

   cmul_mult_sequencer #(.WIDTH(16), .FRAC(15)) dut (
      .clk(clk), .rst_n(rst_n),
      .in_valid(in_valid), .in_ready(in_ready),
      .a_re(a_re), .a_im(a_im), .w_re(w_re), .w_im(w_im),
      .mul_a(mul_a), .mul_b(mul_b), .mul_p(mul_p),
      .out_valid(out_valid), .out_ready(out_ready),
      .y_re(y_re), .y_im(y_im), .y_sat(y_sat)
   );

   assign mul_p = {16'b0, mul_a} * {16'b0, mul_b};

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   task automatic chk(input string nm, input logic [63:0] act,
                      input logic [63:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   task automatic fail_now(input string nm);
      n_tests++;
      n_fail++;
      $display("FAIL %s", nm);
   endtask

   function automatic longint rsat(input longint v, inout logic s);
      longint r;
      r = (v + 64'sd16384) >>> 15;
      if (r > 32767) begin r = 32767; s = 1'b1; end
      else if (r < -32768) begin r = -32768; s = 1'b1; end
      return r;
   endfunction

   function automatic exp_t model(input logic [15:0] ar, ai, wr, wi);
      longint sar, sai, swr, swi, re, im;
      exp_t e;
      sar = longint'($signed(ar));
      sai = longint'($signed(ai));
      swr = longint'($signed(wr));
      swi = longint'($signed(wi));
      e.sat = 1'b0;
      re = rsat(sar * swr - sai * swi, e.sat);
      im = rsat(sar * swi + sai * swr, e.sat);
      e.re = 16'(re);
      e.im = 16'(im);
      e.acc = 0;
      return e;
   endfunction

   function automatic exp_t mk(input logic [15:0] r, i, input logic s);
      exp_t e;
      e.re = r; e.im = i; e.sat = s; e.acc = 0;
      return e;
   endfunction

   function automatic logic [15:0] rv();
      case ($urandom_range(0, 7))
         0: return 16'h8000;
         1: return 16'h7FFF;
         2: return 16'h0000;
         3: return 16'hFFFF;
         default: return 16'($urandom);
      endcase
   endfunction

   task automatic send(input logic [15:0] ar, ai, wr, wi, input exp_t e);
      int n;
      n = 0;
      @(posedge clk); #1;
      while (!in_ready && n < 100) begin
         @(posedge clk); #1;
         n++;
      end
      if (!in_ready) begin
         fail_now("send_timeout");
      end else begin
         a_re = ar; a_im = ai; w_re = wr; w_im = wi;
         in_valid = 1'b1;
         e.acc = cyc;
         sb.push_back(e);
         n_push++;
         @(posedge clk); #1;
         in_valid = 1'b0;
      end
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      while ((sb.size() != 0 || !in_ready) && n < 300) begin
         @(posedge clk); #1;
         n++;
      end
      if (n >= 300) fail_now("idle_timeout");
   endtask

   initial begin : mon
      logic pv, pr, ps;
      logic [15:0] pre, pim;
      exp_t e;
      pv = 0; pr = 0; ps = 0; pre = '0; pim = '0;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            pv = 0;
         end else begin
            if (out_valid) chk("in_ready_in_done", in_ready, 0);
            if (pv && !pr) begin
               chk("hold_valid", out_valid, 1);
               chk("hold_y", {y_sat, y_re, y_im}, {ps, pre, pim});
            end
            if (out_valid && !pv) begin
               if (sb.size() == 0) fail_now("spurious_out");
               else chk("latency", cyc, sb[0].acc + 5);
            end
            if (out_valid && out_ready) begin
               if (sb.size() == 0) begin
                  fail_now("dup_out");
               end else begin
                  e = sb.pop_front();
                  n_pop++;
                  chk("y_re", y_re, e.re);
                  chk("y_im", y_im, e.im);
                  chk("y_sat", y_sat, e.sat);
               end
            end
            pv = out_valid; pr = out_ready;
            ps = y_sat; pre = y_re; pim = y_im;
         end
      end
   end

   initial begin : rdy_gen
      forever begin
         @(posedge clk); #1;
         if (rnd_rdy) out_ready = ($urandom_range(0, 3) != 0);
      end
   end

   initial begin : main
      logic [31:0] seq1 [4];
      int ops, guard, n;
      exp_t e;
      seq1[0] = 32'h4000_4000;
      seq1[1] = 32'h0000_0000;
      seq1[2] = 32'h4000_0000;
      seq1[3] = 32'h0000_4000;

      repeat (3) @(posedge clk);
      #1;
      chk("rst_in_ready", in_ready, 1);
      chk("rst_out_valid", out_valid, 0);
      chk("rst_y", {y_sat, y_re, y_im}, 0);
      chk("rst_mul", {mul_a, mul_b}, 0);
      rst_n = 1'b1;

      send(16'h4000, 16'h0000, 16'h4000, 16'h0000, mk(16'h2000, 16'h0000, 0));
      for (int i = 0; i < 4; i++) begin
         chk("t1_mul_seq", {mul_a, mul_b}, seq1[i]);
         @(posedge clk); #1;
      end
      chk("t1_mul_done", {mul_a, mul_b}, 0);
      wait_idle();

      send(16'h8000, 16'h8000, 16'h8000, 16'h0000, mk(16'h7FFF, 16'h7FFF, 1));
      chk("t2_mul_a", mul_a, 16'h8000);
      wait_idle();

      send(16'h0001, 16'h0000, 16'h4000, 16'h0000, mk(16'h0001, 16'h0000, 0));
      wait_idle();
      send(16'hFFFF, 16'h0000, 16'h4000, 16'h0000, mk(16'h0000, 16'h0000, 0));
      wait_idle();

      out_ready = 1'b0;
      send(16'h4000, 16'h2000, 16'h4000, 16'h0000, mk(16'h2000, 16'h1000, 0));
      n = 0;
      while (!out_valid && n < 20) begin
         @(posedge clk); #1;
         n++;
      end
      if (!out_valid) fail_now("t4_no_valid");
      for (int i = 0; i < 3; i++) begin
         @(posedge clk); #1;
         chk("t4_hold_valid", out_valid, 1);
         chk("t4_in_ready", in_ready, 0);
         chk("t4_y", {y_sat, y_re, y_im}, {1'b0, 16'h2000, 16'h1000});
      end
      out_ready = 1'b1;
      @(posedge clk); #1;
      chk("t4_retire_valid", out_valid, 0);
      chk("t4_retire_ready", in_ready, 1);
      wait_idle();

      send(16'h1111, 16'h2222, 16'h3333, 16'h4444,
           model(16'h1111, 16'h2222, 16'h3333, 16'h4444));
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b0;
      #1;
      chk("t5_rst_valid", out_valid, 0);
      chk("t5_rst_ready", in_ready, 1);
      chk("t5_rst_mul", {mul_a, mul_b}, 0);
      n_push -= sb.size();
      sb.delete();
      @(posedge clk); #1;
      rst_n = 1'b1;
      send(16'h2000, 16'h2000, 16'h4000, 16'hC000, mk(16'h2000, 16'h0000, 0));
      wait_idle();

      rnd_rdy = 1;
      ops = 0;
      guard = 0;
      while (ops < 1000 && guard < 60000) begin
         @(posedge clk); #1;
         guard++;
         if (in_ready && $urandom_range(0, 2) == 0) begin
            a_re = rv(); a_im = rv(); w_re = rv(); w_im = rv();
            in_valid = 1'b1;
            e = model(a_re, a_im, w_re, w_im);
            e.acc = cyc;
            sb.push_back(e);
            n_push++;
            ops++;
         end else begin
            in_valid = !in_ready && ($urandom_range(0, 3) == 0);
            a_re = 16'($urandom); a_im = 16'($urandom);
            w_re = 16'($urandom); w_im = 16'($urandom);
         end
      end
      @(posedge clk); #1;
      in_valid = 1'b0;
      if (ops < 1000) fail_now("random_timeout");
      rnd_rdy = 0;
      @(posedge clk); #2;
      out_ready = 1'b1;
      wait_idle();
      chk("drain_empty", sb.size(), 0);
      chk("pop_count", n_pop, n_push);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
